// File: rtl/game_pkg.sv
// Shared definitions for the sliding-puzzle engine: game status codes,
// move bit indices, move-input FSM encoding and BCD helpers.
package game_pkg;

  localparam int unsigned ACT_W    = 4;
  localparam int unsigned DB_CNT_W = 20;

  localparam logic [1:0] GS_CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GS_GAMING       = 2'b01;
  localparam logic [1:0] GS_GAME_INITIAL = 2'b10;
  localparam logic [1:0] GS_WINNED       = 2'b11;

  localparam int unsigned ACT_UP    = 0;
  localparam int unsigned ACT_RIGHT = 1;
  localparam int unsigned ACT_DOWN  = 2;
  localparam int unsigned ACT_LEFT  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Lowest index wins: up > right > down > left.
  function automatic logic [ACT_W-1:0] pick_winner(input logic [ACT_W-1:0] keys);
    logic [ACT_W-1:0] w;
    w = '0;
    if (keys[ACT_UP])         w[ACT_UP]    = 1'b1;
    else if (keys[ACT_RIGHT]) w[ACT_RIGHT] = 1'b1;
    else if (keys[ACT_DOWN])  w[ACT_DOWN]  = 1'b1;
    else if (keys[ACT_LEFT])  w[ACT_LEFT]  = 1'b1;
    return w;
  endfunction

  // Two-digit BCD increment that sticks at 99.
  function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: two-flop synchronizer followed by a hold-time debouncer
// that only accepts a new level after DB_CYCLES consecutive samples.
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 200000
) (
  input  logic clk_d,
  input  logic rst,
  input  logic btn_i,
  output logic db_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                s1_q, s2_q;
  logic                db_q, db_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_d) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Counter runs only while the synchronized level disagrees with db.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/move_input.sv
// Direction-key front end: debounces four buttons, emits one one-hot move
// pulse per press while GAMING, and keeps a saturating BCD move count.
module move_input
  import game_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 200000
) (
  input  logic             clk_d,
  input  logic             rst,
  input  logic [ACT_W-1:0] btn,
  input  logic [1:0]       game_status,
  output logic [ACT_W-1:0] act,
  output logic [7:0]       move_cnt,
  output logic             cnt_full
);

  logic [ACT_W-1:0] db;
  logic [1:0]       state_q, state_d;
  logic [ACT_W-1:0] act_q, act_d;
  bcd2_t            cnt_q, cnt_d;

  for (genvar i = 0; i < ACT_W; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_d(clk_d),
      .rst  (rst),
      .btn_i(btn[i]),
      .db_o (db[i])
    );
  end

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  // One move per press: any key activity leaves IDLE, and HOLD waits for all
  // keys released, so extra keys and auto-repeat are ignored.
  always_comb begin
    state_d = state_q;
    act_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (db != '0) begin
          if (game_status == GS_GAMING) begin
            state_d = ST_FIRE;
            act_d   = pick_winner(db);
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_FIRE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (db == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear on GAME_INITIAL wins over counting the pulse just emitted.
  always_comb begin
    cnt_d = cnt_q;
    if (game_status == GS_GAME_INITIAL) begin
      cnt_d = '0;
    end else if (act_q != '0) begin
      cnt_d = bcd_inc_sat(cnt_q);
    end
  end

  assign act      = act_q;
  assign move_cnt = cnt_q;
  assign cnt_full = (cnt_q.tens == 4'd9) && (cnt_q.ones == 4'd9);

endmodule

// File: doc/move_input.md
# move_input

Direction-key front end for the sliding-puzzle game engine. It synchronizes and debounces four raw push-buttons and produces the one-cycle, one-hot `act` move pulses consumed by the play engine. Pulses are emitted only while the game is in the GAMING state. The block also keeps a two-digit BCD move count for the score display.

## Interface
Parameters:
- `DB_CYCLES`, default 200000: number of consecutive `clk_d` cycles an input must hold a new level before the debounced value changes. Legal range is 1 to 2^20.

Ports:
- `clk_d`, input, 1: the single clock for the block.
- `rst`, input, 1: reset. Synchronous and active-high.
- `btn`, input, 4: raw buttons, active-high, asynchronous. Bit mapping: `[0]` up, `[1]` right, `[2]` down, `[3]` left.
- `game_status`, input, 2: game state. Encoding: CHOSE_BOARD=00, GAMING=01, GAME_INITIAL=10, WINNED=11.
- `act`, output, 4: move request. One-hot, high for exactly one cycle, same bit mapping as `btn`.
- `move_cnt`, output, 8: moves made, as BCD {tens, ones}.
- `cnt_full`, output, 1: high while `move_cnt` equals 8'h99.

## Operation
- **Synchronizer:** two flip-flops per bit, `btn` to `s1` to `s2`.
- **Debounce, per bit:**
  - State is a counter `cnt` (20 bits) and a debounced level `db`.
  - If `s2 == db`, `cnt` is set to 0.
  - Otherwise, if `cnt == DB_CYCLES-1`, then `db` takes `s2` and `cnt` is set to 0.
  - Otherwise `cnt` increments by 1.
  - Any glitch shorter than `DB_CYCLES` cycles is rejected.
- **FSM:** states are IDLE, FIRE, HOLD.
  - IDLE: if `db != 0`, pick the winner from `db` by priority up > right > down > left (lowest index wins).
    - If `game_status == GAMING`, go to FIRE and register `act` as the one-hot winner.
    - Otherwise go to HOLD and emit no pulse.
  - FIRE: `act` is high during this state only. Go to HOLD unconditionally.
  - HOLD: stay until `db == 4'b0000`, then go to IDLE.
  - Consequence: exactly one move per press. Auto-repeat does not exist. A second key pressed while the first is held is ignored. A key held while entering GAMING does not fire until it is released and pressed again.
- **Move counter:**
  - Increments by 1 in BCD in the cycle after each `act` pulse. Ones digit wraps 9 to 0 with a carry into tens.
  - Saturates at 99. `cnt_full` is then 1.
  - Cleared to 00 whenever `game_status == GAME_INITIAL`. Clear takes priority over increment.
  - Holds its value in all other states, including WINNED, so the final score stays displayed.

## Timing
- **Reset** (synchronous, at the `clk_d` edge where `rst` = 1). The following values apply from the next cycle:
  - `s1`, `s2`, `db`, `cnt` = 0
  - FSM = IDLE
  - `act` = 4'b0000
  - `move_cnt` = 8'h00
  - `cnt_full` = 0
- Reset mid-press: the FSM returns to IDLE with `db` = 0. A button still held after reset is re-debounced and fires once, if in GAMING.
- **Latency:** `btn` is sampled high at edge k and held. `db` rises after edge k+1+`DB_CYCLES`. `act` is high in the cycle after edge k+2+`DB_CYCLES`, i.e. `DB_CYCLES`+3 edges from first sample.
- `act` is registered and never high for two consecutive cycles. Between pulses there are at least 2·`DB_CYCLES` idle cycles, because a release must debounce first.
- `game_status` is sampled in IDLE only. A change during FIRE does not cancel the pulse already registered.
- `move_cnt` updates one cycle after `act`. `cnt_full` is combinational from `move_cnt`.

## Structure
- Shared package `game_pkg` holds:
  - the `game_status` localparams, shared with the play engine;
  - the `act` bit indices (`ACT_UP`=0, `ACT_RIGHT`=1, `ACT_DOWN`=2, `ACT_LEFT`=3);
  - the FSM state encoding.
- Sub-module `btn_debounce`: 1-bit synchronizer plus debouncer, parameter `DB_CYCLES`, instantiated four times.
- The top level contains the priority pick, the FSM and the BCD counter.

## Test plan
All scenarios use `DB_CYCLES`=4.
- **Clean press:** `game_status`=01; `btn`=0001 held 20 cycles. Response: `act`=0001 for exactly 1 cycle, 7 edges after first sample; `move_cnt`=8'h01.
- **Glitch:** `btn[2]` pulsed for 3 cycles. Response: no `act` activity; `db` stays 0.
- **Simultaneous press:** `btn`=1010 pressed together, then `btn[0]` added while held. Response: a single `act`=0010 pulse; no further pulse until all are released and re-pressed.
- **Not in GAMING:** `game_status`=00 with `btn`=0100 held; then switch to 01 while still held. Response: no pulse. Release and press again: `act`=0100 fires once.
- **Counter:** 99 valid presses. Response: `move_cnt`=8'h99 and `cnt_full`=1; a 100th press pulses `act` but the count stays 99. Then `game_status`=10 for one cycle: `move_cnt`=8'h00.
- **Reset mid-hold:** `rst` asserted for 1 cycle in HOLD with `btn`=0001 still held. Response: `act`=0 and `move_cnt`=00; after 7 cycles one new `act`=0001 pulse.
